// File: rtl/ext_in_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ext_in_port_pkg
// Brief   : Shared CPU opcode constants used by the control and I/O blocks.
// Revision: 1.0 - initial release
// ============================================================================
package ext_in_port_pkg;

    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_IN  = 4'h7;

endpackage : ext_in_port_pkg
`default_nettype wire

// File: rtl/ext_in_port_in_fifo_store.sv
`default_nettype none
// ============================================================================
// Module  : in_fifo_store
// Brief   : FIFO storage array with one write port and an asynchronous read mux.
// Revision: 1.0 - initial release
// ============================================================================
module in_fifo_store #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Contents are deliberately left unreset; occupancy alone decides validity.
    always_ff @(negedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule : in_fifo_store
`default_nettype wire

// File: rtl/ext_in_port.sv
`default_nettype none
// ============================================================================
// Module  : ext_in_port
// Brief   : External input port buffering bytes for the CPU IN instruction.
// Revision: 1.0 - initial release
// ============================================================================
module ext_in_port
    import ext_in_port_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           ext_data,
    input  logic                       ext_valid,
    output logic                       ext_ready,
    input  logic [3:0]                 op,
    output logic [WIDTH-1:0]           in_data,
    output logic                       in_stall,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push;
    logic             pop;
    logic             not_empty;
    logic [WIDTH-1:0] rd_data;

    assign not_empty = (count_q != '0);
    assign ext_ready = rst && (count_q < CW'(DEPTH));
    assign push      = ext_valid && ext_ready;
    assign pop       = (op == OP_IN) && not_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State advances on the falling edge to line up with the CPU pipeline.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    in_fifo_store #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_store (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (ext_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign in_data  = not_empty ? rd_data : '0;
    assign in_stall = rst && (op == OP_IN) && !not_empty;
    assign count    = count_q;

endmodule : ext_in_port
`default_nettype wire

// File: tb/tb_ext_in_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_ext_in_port
// Brief   : Scoreboard bench for ext_in_port (falling-edge FIFO for IN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ext_in_port;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b1;
    logic             rst;
    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_data;
    logic             in_stall;
    logic [2:0]       count;

    logic [WIDTH-1:0] sb [$];
    int               n_checks = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    ext_in_port #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .op        (op),
        .in_data   (in_data),
        .in_stall  (in_stall),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs come from the scoreboard queue; the head is the byte IN must see.
    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        check_eq({tag, ".count"},     32'(count),     32'(sb.size()));
        check_eq({tag, ".ext_ready"}, 32'(ext_ready), 32'(sb.size() < DEPTH));
        check_eq({tag, ".in_stall"},  32'(in_stall),  32'((op == 4'h7) && (sb.size() == 0)));
        check_eq({tag, ".in_data"},   32'(in_data),   32'(head));
    endtask

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic [3:0] o,
                         input string tag);
        bit do_push;
        bit do_pop;
        @(posedge clk);
        ext_valid = v;
        ext_data  = d;
        op        = o;
        #1;
        check_outputs(tag);
        do_push = v && (sb.size() < DEPTH);
        do_pop  = (o == 4'h7) && (sb.size() > 0);
        @(negedge clk);
        #1;
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        ext_valid = 1'b1;
        ext_data  = 8'hEE;
        op        = 4'h7;
        #3;
        check_eq("rst.count",     32'(count),     32'd0);
        check_eq("rst.ext_ready", 32'(ext_ready), 32'd0);
        check_eq("rst.in_data",   32'(in_data),   32'd0);
        check_eq("rst.in_stall",  32'(in_stall),  32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        ext_valid = 1'b0;
        op        = 4'h0;
        rst       = 1'b1;

        // Single push, then visible after one falling edge
        cycle(1'b1, 8'hA5, 4'h0, "push_a5");
        cycle(1'b0, 8'h00, 4'h0, "see_a5");
        cycle(1'b0, 8'h00, 4'h7, "pop_a5");
        cycle(1'b0, 8'h00, 4'h0, "empty0");

        // Fill to full; extra byte must be refused
        cycle(1'b1, 8'h11, 4'h0, "fill11");
        cycle(1'b1, 8'h22, 4'h0, "fill22");
        cycle(1'b1, 8'h33, 4'h0, "fill33");
        cycle(1'b1, 8'h44, 4'h0, "fill44");
        cycle(1'b1, 8'h55, 4'h0, "full55a");
        cycle(1'b1, 8'h55, 4'h6, "full55b");

        // Drain from full; the first pop sees a valid byte that must not enter
        cycle(1'b1, 8'h55, 4'h7, "drain1");
        cycle(1'b0, 8'h00, 4'h7, "drain2");
        cycle(1'b0, 8'h00, 4'h7, "drain3");
        cycle(1'b0, 8'h00, 4'h7, "drain4");
        cycle(1'b0, 8'h00, 4'h0, "drained");

        // IN on empty stalls until a byte arrives
        repeat (3) cycle(1'b0, 8'h00, 4'h7, "stall");
        cycle(1'b1, 8'h7E, 4'h7, "stall_push");
        cycle(1'b0, 8'h00, 4'h7, "in_7e");

        // Simultaneous push and pop at count=2
        cycle(1'b1, 8'h01, 4'h0, "pp_a");
        cycle(1'b1, 8'h02, 4'h0, "pp_b");
        cycle(1'b1, 8'h03, 4'h7, "pp_both");
        cycle(1'b0, 8'h00, 4'h0, "pp_after");
        cycle(1'b0, 8'h00, 4'h7, "pp_pop2");
        cycle(1'b0, 8'h00, 4'h7, "pp_pop3");

        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(0, 6));
            cycle(1'($urandom_range(0, 1)), 8'($urandom), o, "rand");
        end
        while (sb.size() > 0) cycle(1'b0, 8'h00, 4'h7, "flush");

        // Reset pulsed between edges with three bytes buffered
        cycle(1'b1, 8'hC1, 4'h0, "pre_rst1");
        cycle(1'b1, 8'hC2, 4'h0, "pre_rst2");
        cycle(1'b1, 8'hC3, 4'h0, "pre_rst3");
        cycle(1'b0, 8'h00, 4'h0, "pre_rst_chk");
        @(posedge clk);
        ext_valid = 1'b1;
        op        = 4'h7;
        #1 rst = 1'b0;
        #1;
        check_eq("mid_rst.count",     32'(count),     32'd0);
        check_eq("mid_rst.ext_ready", 32'(ext_ready), 32'd0);
        check_eq("mid_rst.in_data",   32'(in_data),   32'd0);
        check_eq("mid_rst.in_stall",  32'(in_stall),  32'd0);
        sb.delete();
        ext_valid = 1'b0;
        op        = 4'h0;
        #1 rst = 1'b1;
        #1;
        check_eq("post_rst.count",     32'(count),     32'd0);
        check_eq("post_rst.ext_ready", 32'(ext_ready), 32'd1);
        check_eq("post_rst.in_data",   32'(in_data),   32'd0);

        cycle(1'b1, 8'h9C, 4'h0, "after_rst_push");
        cycle(1'b0, 8'h00, 4'h7, "after_rst_pop");
        cycle(1'b0, 8'h00, 4'h0, "after_rst_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ext_in_port
`default_nettype wire

// File: doc/ext_in_port.md
EXT_IN_PORT -- requirements
Module: ext_in_port

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of buffered input bytes; it SHALL be a power of two, minimum 2.
REQ-002 Parameter WIDTH, default 8, SHALL set the data width; it SHALL match the CPU register width.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its falling edge, as the CPU pipeline does.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 ext_data  input  WIDTH  SHALL carry the byte offered by the external source.
REQ-006 ext_valid  input  1  SHALL indicate ext_data is valid this cycle.
REQ-007 ext_ready  output  1  SHALL indicate the block accepts ext_data this cycle.
REQ-008 op  input  4  SHALL be the opcode of the instruction in the EXE stage.
REQ-009 in_data  output  WIDTH  SHALL be the byte delivered to the IN instruction.
REQ-010 in_stall  output  1  SHALL request a PC/pipeline stall while IN cannot complete.
REQ-011 count  output  log2(DEPTH)+1  SHALL report the number of buffered bytes.

Function
REQ-012 Storage SHALL be a circular FIFO of DEPTH entries with write pointer, read pointer and occupancy count; pointers SHALL wrap modulo DEPTH.
REQ-013 ext_ready SHALL be combinational: 1 when rst=1 and count<DEPTH, else 0.
REQ-014 Push SHALL occur on a falling edge when ext_valid=1 and ext_ready=1: the entry at the write pointer gets ext_data, then the write pointer increments.
REQ-015 Pop SHALL occur on a falling edge when op=4'h7 (IN) and count>0; the read pointer then increments.
REQ-016 in_data SHALL be combinational: the entry at the read pointer when count>0, else 0.
REQ-017 in_stall SHALL be combinational: 1 when op=4'h7 and count=0, else 0.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 On a full FIFO, a pop SHALL proceed, and ext_ready SHALL rise only after the pop edge; no push SHALL occur in the same cycle.
REQ-020 On an empty FIFO, a push with op=4'h7 SHALL store the byte and hold in_stall=1 that cycle; the IN SHALL complete the following cycle with in_data equal to the byte.
REQ-021 Any op other than 4'h7 SHALL cause no pop and no change to in_stall.
REQ-022 Latency SHALL be one falling edge from an accepted push to that byte appearing on in_data when the FIFO was empty.
REQ-023 Byte order SHALL be strictly first-in first-out; no byte SHALL be dropped or duplicated.

Reset
REQ-024 When rst=0, pointers and count SHALL clear to 0 immediately, regardless of clk.
REQ-025 While rst=0, outputs SHALL be ext_ready=0, in_data=0, count=0 and in_stall=0.
REQ-026 Storage contents need not clear.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered bytes; no push or pop SHALL occur on an edge coincident with reset.

Structure
REQ-028 Opcode constants OP_IN=4'h7 and OP_OUT=4'h6 SHALL live in the shared CPU package, used with the existing control blocks.
REQ-029 The storage array SHALL be one sub-module, in_fifo_store, holding the write port and the read mux.
REQ-030 Pointer and count logic SHALL stay in ext_in_port.

Verification
REQ-031 Reset, then push 8'hA5 with op=0 -> count=1 and in_data=8'hA5 after one falling edge, ext_ready=1.
REQ-032 Push 8'h11, 8'h22, 8'h33, 8'h44 with no IN -> count=4 and ext_ready=0; a fifth byte 8'h55 held valid is not accepted.
REQ-033 From full, op=4'h7 for four cycles -> in_data reads 8'h11, 8'h22, 8'h33, 8'h44 in order, and count falls to 0.
REQ-034 Empty FIFO with op=4'h7 held and no push -> in_stall=1 every cycle; push 8'h7E -> in_stall=0 the next cycle with in_data=8'h7E.
REQ-035 count=2 with push and IN on the same edge -> count stays 2 and the oldest byte leaves first.
REQ-036 count=3 mid-stream, then rst pulsed low between clock edges -> count=0, ext_ready=0 during reset and 1 after release, and in_data=0.
